ext_mem_arbiter: RTL and testbench
==================================

Name: ext_mem_arbiter

Overview:
- Shares one single-port external memory between the instruction-fetch port (read-only) and the data port (read/write).
- Arbitrates between the two ports round-robin and latches the winning request.
- Drives the memory's level-sensitive address/enable/data pins for a programmable number of wait cycles, then returns read data with a one-cycle ready pulse.
- Sits between the pipeline's fetch and memory stages and the external memory model.

Parameters:
- MEM_WIDTH, 32, data word width.
- MEM_SIZE, 256, memory depth in words; address width ADDR_W = $clog2(MEM_SIZE), derived, not overridable.
- WAIT_CYCLES, 2, cycles the memory pins are held per access; legal range 1 to 15.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ready.
- i_addr  in  ADDR_W  fetch word address.
- i_ready  out  1  one-cycle pulse: fetch complete.
- i_rdata  out  MEM_WIDTH  last fetched word.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  MEM_WIDTH  write data.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  MEM_WIDTH  last data-read word.
- mem_addr  out  ADDR_W  memory address.
- mem_read_en  out  1  memory read enable.
- mem_write_en  out  1  memory write enable.
- mem_write_val  out  MEM_WIDTH  memory write data.
- mem_read_val  in  MEM_WIDTH  memory read data; combinational from memory.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: clk and reset as named above; reset is synchronous, active-high.
  - After the reset edge, every output is 0, state = IDLE, last_grant = D, and the wait counter and latched request registers are 0.
- Reset mid-access: the access is aborted and no ready pulse is issued. mem_write_en and mem_read_en are low in the cycle after the reset edge. A partially held write may already have reached memory; this is acceptable.
- FSM states and transitions:
  - IDLE -> ACCESS when i_req or d_req is high.
  - ACCESS -> DONE when the wait counter reaches 0.
  - DONE -> IDLE unconditionally.
- Arbitration, evaluated in IDLE only:
  - Only one request high: grant it.
  - Both high: grant the port that is not last_grant. Because last_grant resets to D, fetch wins the first tie.
  - last_grant updates on every grant.
- Grant edge:
  - Latch addr, we and wdata from the winner; reads from the I port force we = 0.
  - Load the counter with WAIT_CYCLES-1 and enter ACCESS.
- ACCESS:
  - mem_addr, mem_write_val and mem_write_en (= we) come from the latched registers; mem_read_en = ~we. All are stable for exactly WAIT_CYCLES cycles.
  - The counter decrements each cycle.
  - At counter == 0 on a read, register mem_read_val into the granted port's rdata at that edge.
  - Enter DONE.
- DONE:
  - The granted port's ready is high for exactly this cycle; all mem enables are low.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle 0 -> ready high in cycle WAIT_CYCLES+1.
  - Minimum spacing between grants is WAIT_CYCLES+2 cycles, because IDLE always lasts at least one cycle.
- Handshake rules:
  - Requesters hold req and their fields stable until they sample ready, then may drop req the following cycle.
  - req still high in the IDLE cycle after DONE counts as a new request.
  - req dropped mid-access is ignored: the access completes and ready still pulses.
  - Input changes after the grant edge have no effect.
- Read-data hold:
  - i_rdata and d_rdata hold their value until the next completed read on that port.
  - Writes never change d_rdata; D accesses never change i_rdata.
- Addresses: full ADDR_W range, so no out-of-range case exists. No wrap logic is needed.
- mem_read_en and mem_write_en are never high simultaneously.

Decomposition:
- Shared header ext_mem_arbiter_defs.vh, holding:
  - FSM state encodings (IDLE, ACCESS, DONE);
  - grant encodings (GNT_I, GNT_D);
  - the WAIT_CYCLES legal-range check macro.
- One sub-module, rr_arbiter_2: two requests plus a last-grant register produce a one-hot grant and a grant-valid flag. It is reusable for later caches.

Test Plan:
- WAIT_CYCLES=2; memory[212]=32'h00001825; i_req with i_addr=212 at cycle 0 -> mem_read_en high in cycles 1-2, i_ready high in cycle 3 only, i_rdata=32'h00001825, d_rdata unchanged.
- D write addr 5 data 32'hDEADBEEF, then D read addr 5 -> mem_write_en high exactly 2 cycles; second d_ready gives d_rdata=32'hDEADBEEF; i_rdata unchanged.
- After reset, i_req and d_req both held high continuously -> grant order I, D, I, D, with each ready spaced 4 cycles apart.
- reset asserted during ACCESS of a D write -> next cycle mem_write_en=0, busy=0, d_ready never pulses, all outputs 0.
- WAIT_CYCLES=1; d_req read addr 0 -> d_ready in cycle 2. d_req dropped in cycle 1 -> access still completes and d_ready still pulses.
- Throughout all scenarios the bench checks: mem_read_en & mem_write_en never both 1; mem_* pins stable through each ACCESS; i_ready & d_ready never both 1.

Source files
------------

// File: rtl/ext_mem_arbiter_pkg.sv
// Shared types and constants for the external-memory arbiter and its round-robin helper.
package ext_mem_arbiter_pkg;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WAIT_MIN = 1;
    localparam int unsigned WAIT_MAX = 15;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    typedef enum logic {
        GntI = 1'b0,
        GntD = 1'b1
    } grant_e;

    function automatic bit wait_cycles_ok(int unsigned w);
        return (w >= WAIT_MIN) && (w <= WAIT_MAX);
    endfunction

endpackage

// File: rtl/ext_mem_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter: one-hot grant (bit 0 = fetch, bit 1 = data) plus valid.
module rr_arbiter_2
    import ext_mem_arbiter_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  grant_e     i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_valid
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req_i && i_req_d) begin
            // Tie goes to whichever port was not served last.
            o_grant = (i_last_grant == GntD) ? 2'b01 : 2'b10;
        end else if (i_req_i) begin
            o_grant = 2'b01;
        end else if (i_req_d) begin
            o_grant = 2'b10;
        end
    end

    assign o_valid = i_req_i | i_req_d;

endmodule

// File: rtl/ext_mem_arbiter.sv
// Shares one single-port external memory between the fetch port and the data port,
// holding the memory pins for WAIT_CYCLES cycles per access and pulsing ready once.
module ext_mem_arbiter
    import ext_mem_arbiter_pkg::*;
#(
    parameter int unsigned  MEM_WIDTH   = 32,
    parameter int unsigned  MEM_SIZE    = 256,
    parameter int unsigned  WAIT_CYCLES = 2,
    localparam int unsigned ADDR_W      = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_ready,
    output logic [MEM_WIDTH-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [MEM_WIDTH-1:0] d_wdata,
    output logic                 d_ready,
    output logic [MEM_WIDTH-1:0] d_rdata,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [MEM_WIDTH-1:0] mem_write_val,
    input  logic [MEM_WIDTH-1:0] mem_read_val,
    output logic                 busy
);

    if (!wait_cycles_ok(WAIT_CYCLES)) begin : g_bad_wait_cycles
        $error("WAIT_CYCLES must lie in 1..15");
    end

    state_e               r_state;
    grant_e               r_last_grant;
    grant_e               r_gnt;
    logic [CNT_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_we;
    logic [MEM_WIDTH-1:0] r_wdata;
    logic                 r_i_ready;
    logic                 r_d_ready;
    logic [MEM_WIDTH-1:0] r_i_rdata;
    logic [MEM_WIDTH-1:0] r_d_rdata;
    logic                 r_rd_en;
    logic                 r_wr_en;
    logic                 r_busy;

    logic [1:0] w_grant;
    logic       w_gnt_valid;
    logic       w_gnt_d;
    logic       w_gnt_we;

    rr_arbiter_2 u_rr_arbiter_2 (
        .i_req_i      (i_req),
        .i_req_d      (d_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_gnt_valid)
    );

    assign w_gnt_d  = (w_grant == 2'b10);
    assign w_gnt_we = w_gnt_d & d_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_last_grant <= GntD;
            r_gnt        <= GntI;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_i_ready    <= 1'b0;
            r_d_ready    <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_gnt_valid) begin
                        r_gnt        <= w_gnt_d ? GntD : GntI;
                        r_last_grant <= w_gnt_d ? GntD : GntI;
                        r_addr       <= w_gnt_d ? d_addr : i_addr;
                        r_we         <= w_gnt_we;
                        r_wdata      <= w_gnt_d ? d_wdata : '0;
                        r_cnt        <= CNT_W'(WAIT_CYCLES - 1);
                        r_rd_en      <= ~w_gnt_we;
                        r_wr_en      <= w_gnt_we;
                        r_busy       <= 1'b1;
                        r_state      <= StAccess;
                    end
                end
                StAccess: begin
                    if (r_cnt == '0) begin
                        // Last held cycle: memory output is valid, capture it for reads.
                        if (!r_we) begin
                            if (r_gnt == GntI) r_i_rdata <= mem_read_val;
                            else               r_d_rdata <= mem_read_val;
                        end
                        r_rd_en   <= 1'b0;
                        r_wr_en   <= 1'b0;
                        r_i_ready <= (r_gnt == GntI);
                        r_d_ready <= (r_gnt == GntD);
                        r_state   <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign i_ready       = r_i_ready;
    assign d_ready       = r_d_ready;
    assign i_rdata       = r_i_rdata;
    assign d_rdata       = r_d_rdata;
    assign mem_addr      = r_addr;
    assign mem_write_val = r_wdata;
    assign mem_read_en   = r_rd_en;
    assign mem_write_en  = r_wr_en;
    assign busy          = r_busy;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model (reference memory, latency window, read-data hold).
module tb_ext_mem_arbiter;

    localparam int unsigned W  = 2;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [31:0]   d_wdata, i_rdata, d_rdata, mem_write_val, mem_read_val;
    logic          i_ready, d_ready, mem_read_en, mem_write_en, busy;

    logic          b_reset, b_i_req, b_d_req, b_d_we;
    logic [AW-1:0] b_i_addr, b_d_addr, b_mem_addr;
    logic [31:0]   b_d_wdata, b_i_rdata, b_d_rdata, b_mem_write_val, b_mem_read_val;
    logic          b_i_ready, b_d_ready, b_mem_read_en, b_mem_write_en, b_busy;

    logic [31:0]   mem_a   [256];
    logic [31:0]   ref_mem [256];
    logic          tb_we;
    logic [AW-1:0] tb_waddr;
    logic [31:0]   tb_wdata;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_i, exp_d;

    ext_mem_arbiter #(.MEM_WIDTH(32), .MEM_SIZE(256), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_write_val(mem_write_val), .mem_read_val(mem_read_val), .busy(busy)
    );

    ext_mem_arbiter #(.MEM_WIDTH(32), .MEM_SIZE(256), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .reset(b_reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en),
        .mem_write_val(b_mem_write_val), .mem_read_val(b_mem_read_val), .busy(b_busy)
    );

    // Memory model for the main DUT; the bench can also poke words in while the DUT is idle.
    assign mem_read_val = mem_a[mem_addr];
    always @(posedge clk) begin
        if (mem_write_en)  mem_a[mem_addr] <= mem_write_val;
        else if (tb_we)    mem_a[tb_waddr] <= tb_wdata;
    end

    // The WAIT_CYCLES=1 instance only reads; its memory is an address-derived pattern.
    assign b_mem_read_val = 32'hC0DE_0000 | 32'(b_mem_addr);

    // Pin invariants on the main DUT, checked every cycle.
    logic          rst_at_edge;
    int unsigned   en_run = 0;
    logic          prev_en = 1'b0, prev_rd;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_wval;
    always @(posedge clk) rst_at_edge <= reset;

    always @(negedge clk) begin
        n_total++;
        if (mem_read_en && mem_write_en)
            $display("FAIL en_excl: read_en=%b write_en=%b, want not both 1", mem_read_en, mem_write_en);
        else n_pass++;
        n_total++;
        if (i_ready && d_ready)
            $display("FAIL ready_excl: i_ready=%b d_ready=%b, want not both 1", i_ready, d_ready);
        else n_pass++;
        if (rst_at_edge === 1'b1) begin
            en_run  = 0;
            prev_en = 1'b0;
        end else if (mem_read_en || mem_write_en) begin
            if (prev_en) begin
                n_total++;
                if ({mem_addr, mem_write_val, mem_read_en} !== {prev_addr, prev_wval, prev_rd})
                    $display("FAIL pins_stable: got %h/%h/%b, want %h/%h/%b", mem_addr,
                             mem_write_val, mem_read_en, prev_addr, prev_wval, prev_rd);
                else n_pass++;
            end
            en_run++;
            prev_en   = 1'b1;
            prev_addr = mem_addr;
            prev_wval = mem_write_val;
            prev_rd   = mem_read_en;
        end else begin
            if (en_run != 0) begin
                n_total++;
                if (en_run != W) $display("FAIL en_len: enable held %0d cycles, want %0d", en_run, W);
                else n_pass++;
            end
            en_run  = 0;
            prev_en = 1'b0;
        end
    end

    task automatic test_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({i_ready, d_ready, mem_read_en, mem_write_en, busy} !== 5'b0)
            $display("FAIL reset_ctrl: got %b, want 00000",
                     {i_ready, d_ready, mem_read_en, mem_write_en, busy});
        else n_pass++;
        n_total++;
        if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h/%h, want 0/0", i_rdata, d_rdata);
        else n_pass++;
        n_total++;
        if ({mem_addr, mem_write_val} !== 40'h0)
            $display("FAIL reset_mem_pins: got %h/%h, want 0/0", mem_addr, mem_write_val);
        else n_pass++;
        reset = 1'b0;
        exp_i = '0; exp_d = '0;
    endtask

    task automatic preload();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_waddr = a[7:0]; tb_wdata = $urandom;
            ref_mem[a] = tb_wdata;
        end
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = 8'd212; tb_wdata = 32'h0000_1825;
        ref_mem[212] = 32'h0000_1825;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic test_fetch_read();
        i_addr = 8'd212; i_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_total++;
            if (mem_read_en !== (k <= 2)) $display("FAIL fetch_rd_en c%0d: got %b, want %b", k, mem_read_en, k <= 2);
            else n_pass++;
            n_total++;
            if (i_ready !== (k == 3)) $display("FAIL fetch_ready c%0d: got %b, want %b", k, i_ready, k == 3);
            else n_pass++;
            if (k <= 2) begin
                n_total++;
                if (mem_addr !== 8'd212) $display("FAIL fetch_addr c%0d: got %0d, want 212", k, mem_addr);
                else n_pass++;
            end
            if (k == 3) begin
                n_total++;
                if (i_rdata !== 32'h0000_1825) $display("FAIL fetch_rdata: got %h, want 00001825", i_rdata);
                else n_pass++;
                exp_i = 32'h0000_1825;
                i_req = 1'b0;
            end
        end
        n_total++;
        if (d_rdata !== exp_d) $display("FAIL fetch_d_rdata_hold: got %h, want %h", d_rdata, exp_d);
        else n_pass++;
    endtask

    task automatic test_write_read();
        int wr_cnt = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd5; d_wdata = 32'hDEAD_BEEF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (mem_write_en) wr_cnt++;
            n_total++;
            if (d_ready !== (k == 3)) $display("FAIL wr_ready c%0d: got %b, want %b", k, d_ready, k == 3);
            else n_pass++;
        end
        n_total++;
        if (wr_cnt != 2) $display("FAIL wr_en_cycles: got %0d, want 2", wr_cnt);
        else n_pass++;
        n_total++;
        if (d_rdata !== exp_d) $display("FAIL wr_d_rdata_hold: got %h, want %h", d_rdata, exp_d);
        else n_pass++;
        n_total++;
        if (mem_a[5] !== 32'hDEAD_BEEF) $display("FAIL wr_mem: got %h, want deadbeef", mem_a[5]);
        else n_pass++;
        ref_mem[5] = 32'hDEAD_BEEF;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        d_req = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            n_total++;
            if (d_ready !== (k == 7)) $display("FAIL rd_ready c%0d: got %b, want %b", k, d_ready, k == 7);
            else n_pass++;
        end
        n_total++;
        if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h, want deadbeef", d_rdata);
        else n_pass++;
        n_total++;
        if (i_rdata !== exp_i) $display("FAIL rd_i_rdata_hold: got %h, want %h", i_rdata, exp_i);
        else n_pass++;
        exp_d = 32'hDEAD_BEEF;
        d_req = 1'b0;
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; exp_i = '0; exp_d = '0;
        i_addr = 8'($urandom_range(0, 15)); d_addr = 8'($urandom_range(0, 15)); d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_total++;
            if (i_ready !== (k == 3 || k == 11))
                $display("FAIL rr_i_ready c%0d: got %b, want %b", k, i_ready, k == 3 || k == 11);
            else n_pass++;
            n_total++;
            if (d_ready !== (k == 7 || k == 15))
                $display("FAIL rr_d_ready c%0d: got %b, want %b", k, d_ready, k == 7 || k == 15);
            else n_pass++;
            if (k == 3) exp_i = ref_mem[i_addr];
            if (k == 7) exp_d = ref_mem[d_addr];
            n_total++;
            if (i_rdata !== exp_i || d_rdata !== exp_d)
                $display("FAIL rr_rdata c%0d: got %h/%h, want %h/%h", k, i_rdata, d_rdata, exp_i, exp_d);
            else n_pass++;
            if (k == 15) begin i_req = 1'b0; d_req = 1'b0; end
        end
    endtask

    task automatic test_reset_mid_access();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd100; d_wdata = $urandom;
        @(negedge clk);
        n_total++;
        if ({mem_write_en, busy} !== 2'b11) $display("FAIL rst_mid_pre: got %b, want 11", {mem_write_en, busy});
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({i_ready, d_ready, mem_read_en, mem_write_en, busy, i_rdata, d_rdata, mem_addr, mem_write_val} !== '0)
            $display("FAIL rst_mid_outputs: got %b/%h/%h/%h/%h, want all 0",
                     {i_ready, d_ready, mem_read_en, mem_write_en, busy}, i_rdata, d_rdata, mem_addr, mem_write_val);
        else n_pass++;
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
        exp_i = '0; exp_d = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_total++;
            if ({d_ready, busy} !== 2'b00) $display("FAIL rst_mid_no_ready c%0d: got %b, want 00", k, {d_ready, busy});
            else n_pass++;
        end
    endtask

    task automatic test_wait1();
        b_reset = 1'b1;
        @(negedge clk);
        b_reset = 1'b0; b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 8'd0;
        @(negedge clk);
        n_total++;
        if ({b_mem_read_en, b_d_ready} !== 2'b10) $display("FAIL w1_c1: got %b, want 10", {b_mem_read_en, b_d_ready});
        else n_pass++;
        b_d_req = 1'b0;
        @(negedge clk);
        n_total++;
        if ({b_mem_read_en, b_mem_write_en, b_d_ready} !== 3'b001)
            $display("FAIL w1_c2: got %b, want 001", {b_mem_read_en, b_mem_write_en, b_d_ready});
        else n_pass++;
        n_total++;
        if (b_d_rdata !== 32'hC0DE_0000) $display("FAIL w1_rdata: got %h, want c0de0000", b_d_rdata);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({b_d_ready, b_busy, b_i_ready} !== 3'b000) $display("FAIL w1_c3: got %b, want 000", {b_d_ready, b_busy, b_i_ready});
        else n_pass++;
    endtask

    task automatic test_random();
        bit ip = 0, dp = 0, dw = 0;
        int it0 = 0, dt0 = 0, lat;
        logic [AW-1:0] ia = '0, da = '0;
        logic [31:0] dwd = '0;
        i_req = 1'b0; d_req = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (i_ready) begin
                lat = cyc - it0;
                n_total++;
                if (!ip || lat < int'(W) + 1 || lat > 2 * int'(W) + 4)
                    $display("FAIL rand_i_lat: pending=%b latency %0d, want %0d..%0d", ip, lat, W + 1, 2 * W + 4);
                else n_pass++;
                n_total++;
                if (i_rdata !== ref_mem[ia]) $display("FAIL rand_i_rdata: got %h, want %h", i_rdata, ref_mem[ia]);
                else n_pass++;
                exp_i = ref_mem[ia];
                ip = 0;
            end
            if (d_ready) begin
                lat = cyc - dt0;
                n_total++;
                if (!dp || lat < int'(W) + 1 || lat > 2 * int'(W) + 4)
                    $display("FAIL rand_d_lat: pending=%b latency %0d, want %0d..%0d", dp, lat, W + 1, 2 * W + 4);
                else n_pass++;
                if (dw) ref_mem[da] = dwd;
                else begin
                    n_total++;
                    if (d_rdata !== ref_mem[da]) $display("FAIL rand_d_rdata: got %h, want %h", d_rdata, ref_mem[da]);
                    else n_pass++;
                    exp_d = ref_mem[da];
                end
                dp = 0;
            end
            n_total++;
            if (i_rdata !== exp_i || d_rdata !== exp_d)
                $display("FAIL rand_rdata_hold: got %h/%h, want %h/%h", i_rdata, d_rdata, exp_i, exp_d);
            else n_pass++;
            if (ip && cyc - it0 > 2 * int'(W) + 4) begin
                n_total++;
                $display("FAIL rand_i_timeout: no i_ready after %0d cycles, want <= %0d", cyc - it0, 2 * W + 4);
                ip = 0;
            end
            if (dp && cyc - dt0 > 2 * int'(W) + 4) begin
                n_total++;
                $display("FAIL rand_d_timeout: no d_ready after %0d cycles, want <= %0d", cyc - dt0, 2 * W + 4);
                dp = 0;
            end
            if (!ip) begin
                if ($urandom_range(0, 2) == 0) begin
                    ia = 8'($urandom_range(0, 15));
                    i_addr = ia; i_req = 1'b1; ip = 1; it0 = cyc;
                end else i_req = 1'b0;
            end
            if (!dp) begin
                if ($urandom_range(0, 2) == 0) begin
                    da = 8'($urandom_range(0, 15)); dw = 1'($urandom_range(0, 1)); dwd = $urandom;
                    d_addr = da; d_we = dw; d_wdata = dwd; d_req = 1'b1; dp = 1; dt0 = cyc;
                end else d_req = 1'b0;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (2 * W + 6) @(negedge clk);
    endtask

    initial begin
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        b_reset = 1'b1; b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_d_addr = '0; b_d_wdata = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = '0;
        test_reset();
        preload();
        test_fetch_read();
        test_write_read();
        test_round_robin();
        test_reset_mid_access();
        test_wait1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
